// File: rtl/multi_dispatcher.sv
// Multi-channel FIFO dispatcher: per-channel FIFOs, round-robin arbitration with optional
// packet lock, and a single registered AXI-Stream output stage toward the NoC.
module multi_dispatcher #(
  parameter int unsigned               DATAW       = 512,
  parameter int unsigned               IDW         = 2,
  parameter int unsigned               DESTW       = 4,
  parameter int unsigned               NUM_CH      = 3,
  parameter int unsigned               FIFO_DEPTH  = 8,
  parameter logic [NUM_CH*DESTW-1:0]   DEST_NODES  = {4'd9, 4'd1, 4'd2},
  parameter bit                        PACKET_LOCK = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       data_fifo_wen,
  input  logic [NUM_CH*DATAW-1:0] data_fifo_wdata,
  input  logic [NUM_CH-1:0]       data_last,
  output logic [NUM_CH-1:0]       data_fifo_rdy,
  output logic                    axis_tx_tvalid,
  output logic [DATAW-1:0]        axis_tx_tdata,
  output logic [IDW-1:0]          axis_tx_tid,
  output logic [DESTW-1:0]        axis_tx_tdest,
  output logic                    axis_tx_tlast,
  input  logic                    axis_tx_tready
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  if (NUM_CH < 1 || NUM_CH > (1 << IDW) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_err
    $error("multi_dispatcher: illegal NUM_CH/IDW/FIFO_DEPTH combination");
  end

  logic [DATAW:0]                mem [NUM_CH][FIFO_DEPTH];
  logic [NUM_CH-1:0][AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [NUM_CH-1:0][CW-1:0]     count_q;
  logic                          run_q;

  logic [NUM_CH-1:0] wr_en, pop, nonempty;
  logic [IDW-1:0]    rr_q, lock_ch_q, grant;
  logic              lock_q, grant_vld, load, pop_any;
  logic [DATAW:0]    head;
  int                idx;

  // run_q keeps rdy low throughout reset and raises it on the first edge afterwards.
  always_comb begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      nonempty[c]      = (count_q[c] != '0);
      data_fifo_rdy[c] = run_q && (count_q[c] < CW'(FIFO_DEPTH));
    end
    wr_en = data_fifo_wen & data_fifo_rdy;
  end

  // Descending scan so the first non-empty channel after rr_q is the one left standing.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (lock_q) begin
      grant     = lock_ch_q;
      grant_vld = nonempty[lock_ch_q];
    end else begin
      for (int i = int'(NUM_CH); i >= 1; i--) begin
        idx = (int'(rr_q) + i) % int'(NUM_CH);
        if (nonempty[idx]) begin
          grant     = IDW'(idx);
          grant_vld = 1'b1;
        end
      end
    end
    load    = !axis_tx_tvalid || axis_tx_tready;
    pop_any = load && grant_vld;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      pop[c] = pop_any && (grant == IDW'(c));
    end
    head = mem[grant][rd_ptr_q[grant]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      run_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      for (int c = 0; c < int'(NUM_CH); c++) begin
        if (wr_en[c]) wr_ptr_q[c] <= wr_ptr_q[c] + AW'(1);
        if (pop[c])   rd_ptr_q[c] <= rd_ptr_q[c] + AW'(1);
        if (wr_en[c] && !pop[c]) begin
          count_q[c] <= count_q[c] + CW'(1);
        end else if (!wr_en[c] && pop[c]) begin
          count_q[c] <= count_q[c] - CW'(1);
        end
      end
    end
  end

  // Storage is not reset; pointers and counts alone decide what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (wr_en[c]) begin
        mem[c][wr_ptr_q[c]] <= {data_last[c], data_fifo_wdata[c*DATAW +: DATAW]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      axis_tx_tvalid <= 1'b0;
      axis_tx_tdata  <= '0;
      axis_tx_tid    <= '0;
      axis_tx_tdest  <= '0;
      axis_tx_tlast  <= 1'b0;
      rr_q           <= IDW'(NUM_CH - 1);
      lock_q         <= 1'b0;
      lock_ch_q      <= '0;
    end else if (load) begin
      axis_tx_tvalid <= grant_vld;
      if (grant_vld) begin
        axis_tx_tdata <= head[DATAW-1:0];
        axis_tx_tlast <= head[DATAW];
        axis_tx_tid   <= grant;
        axis_tx_tdest <= DEST_NODES[grant*DESTW +: DESTW];
        rr_q          <= grant;
        if (PACKET_LOCK) begin
          lock_q    <= !head[DATAW];
          lock_ch_q <= grant;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_dispatcher.sv
// Bench for multi_dispatcher: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_multi_dispatcher;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  wen = '0;
  logic [95:0] wdata = '0;
  logic [2:0]  last = '0;
  logic        tready = 1'b1;

  logic [2:0]  rdy, rdy_b;
  logic        tvalid, tvalid_b, tlast, tlast_b;
  logic [31:0] tdata, tdata_b;
  logic [1:0]  tid, tid_b;
  logic [3:0]  tdest, tdest_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_dispatcher #(.DATAW(32), .PACKET_LOCK(1'b1)) dut (
    .clk(clk), .rst(rst), .data_fifo_wen(wen), .data_fifo_wdata(wdata), .data_last(last),
    .data_fifo_rdy(rdy), .axis_tx_tvalid(tvalid), .axis_tx_tdata(tdata), .axis_tx_tid(tid),
    .axis_tx_tdest(tdest), .axis_tx_tlast(tlast), .axis_tx_tready(tready)
  );

  multi_dispatcher #(.DATAW(32), .PACKET_LOCK(1'b0)) dut_b (
    .clk(clk), .rst(rst), .data_fifo_wen(wen), .data_fifo_wdata(wdata), .data_last(last),
    .data_fifo_rdy(rdy_b), .axis_tx_tvalid(tvalid_b), .axis_tx_tdata(tdata_b),
    .axis_tx_tid(tid_b), .axis_tx_tdest(tdest_b), .axis_tx_tlast(tlast_b),
    .axis_tx_tready(tready)
  );

  function automatic logic [3:0] dest_of(input int c);
    case (c)
      0:       return 4'd2;
      1:       return 4'd1;
      default: return 4'd9;
    endcase
  endfunction

  // Reference model of the locked instance: channel queues plus one output slot.
  logic [32:0] mq[3][$];
  int          m_last_g, m_lock_ch, m_tid;
  bit          m_lock, m_valid, m_run, m_tlast;
  logic [31:0] m_data;
  logic [3:0]  m_tdest;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) mq[c].delete();
      m_last_g = 2; m_lock = 0; m_lock_ch = 0; m_valid = 0; m_run = 0;
      m_data = '0; m_tid = 0; m_tdest = '0; m_tlast = 0;
    end else begin : step
      bit acc[3];
      int sel;
      logic [32:0] e;
      for (int c = 0; c < 3; c++) acc[c] = m_run && wen[c] && (mq[c].size() < 8);
      if (!m_valid || tready) begin
        sel = -1;
        if (m_lock) begin
          if (mq[m_lock_ch].size() > 0) sel = m_lock_ch;
        end else begin
          for (int i = 1; i <= 3; i++)
            if (sel < 0 && mq[(m_last_g + i) % 3].size() > 0) sel = (m_last_g + i) % 3;
        end
        m_valid = (sel >= 0);
        if (sel >= 0) begin
          e = mq[sel].pop_front();
          m_data = e[31:0]; m_tlast = e[32]; m_tid = sel; m_tdest = dest_of(sel);
          m_last_g = sel; m_lock = !e[32]; m_lock_ch = sel;
        end
      end
      for (int c = 0; c < 3; c++) if (acc[c]) mq[c].push_back({last[c], wdata[c*32 +: 32]});
      m_run = 1;
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0] er;
    logic [1:0] et;
    for (int c = 0; c < 3; c++) er[c] = m_run && (mq[c].size() < 8);
    et = m_tid[1:0];
    checks++;
    if (rdy !== er || tvalid !== m_valid) begin
      errors++;
      $display("FAIL ctrl t=%0t rdy=%b tvalid=%b required rdy=%b tvalid=%b",
               $time, rdy, tvalid, er, m_valid);
    end
    if (m_valid || rst) begin
      checks++;
      if ({tdata, tid, tdest, tlast} !== {m_data, et, m_tdest, m_tlast}) begin
        errors++;
        $display("FAIL beat t=%0t data=%h id=%0d dest=%0d last=%b required %h %0d %0d %b",
                 $time, tdata, tid, tdest, tlast, m_data, et, m_tdest, m_tlast);
      end
    end
  end

  bit          rec_en = 0;
  logic [31:0] rec_data[$];
  int          rec_tid[$], rec_tid_b[$];

  always @(negedge clk) begin
    if (rec_en && tready) begin
      if (tvalid) begin rec_data.push_back(tdata); rec_tid.push_back(int'(tid)); end
      if (tvalid_b) rec_tid_b.push_back(int'(tid_b));
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int c, input logic [31:0] d);
    wdata[c*32 +: 32] = d;
  endtask

  task automatic rec_start();
    rec_data.delete(); rec_tid.delete(); rec_tid_b.delete();
    rec_en = 1;
  endtask

  task automatic do_reset();
    wen = '0; last = '0; rec_en = 0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    chk("reset_rdy", 64'(rdy), 64'h0);
    chk("reset_tvalid", 64'(tvalid), 64'h0);
    chk("reset_payload", {tdata, tid, tdest, tlast}, 64'h0);
    rst = 1'b0;
    tick();
    chk("rdy_after_release", 64'(rdy), 64'h7);

    // Single beat on ch0
    tready = 1'b1;
    wen = 3'b001; last = 3'b001; put(0, 32'hA5);
    tick();
    wen = '0; last = '0;
    chk("single_not_yet", 64'(tvalid), 64'h0);
    tick();
    chk("single_beat", {tvalid, tdata, tid, tdest, tlast}, {1'b1, 32'hA5, 2'd0, 4'd2, 1'b1});
    tick();
    chk("single_once", 64'(tvalid), 64'h0);

    // Backpressure on ch1
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wen = 3'b010; put(1, 32'h11 * (i + 1)); last = (i == 2) ? 3'b010 : 3'b000;
      tick();
    end
    wen = '0; last = '0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {tvalid, tdata, tid, tdest}, {1'b1, 32'h11, 2'd1, 4'd1});
      tick();
    end
    tready = 1'b1;
    chk("bp_b0", {tvalid, tdata, tlast}, {1'b1, 32'h11, 1'b0});
    tick();
    chk("bp_b1", {tvalid, tdata, tlast}, {1'b1, 32'h22, 1'b0});
    tick();
    chk("bp_b2", {tvalid, tdata, tid, tdest, tlast}, {1'b1, 32'h33, 2'd1, 4'd1, 1'b1});
    tick();
    chk("bp_done", 64'(tvalid), 64'h0);

    // Full FIFO on ch2 while the output slot is held by a ch0 beat
    do_reset();
    tready = 1'b0;
    wen = 3'b001; last = 3'b001; put(0, 32'h77);
    tick();
    wen = '0; last = '0;
    tick();
    for (int i = 0; i < 9; i++) begin
      wen = 3'b100; put(2, 32'h200 + i); last = (i >= 7) ? 3'b100 : 3'b000;
      tick();
      if (i == 7) chk("full_rdy2", 64'(rdy), 64'h3);
    end
    wen = '0; last = '0;
    tready = 1'b1;
    rec_start();
    repeat (14) tick();
    rec_en = 0;
    chk("full_count", 64'(rec_data.size()), 64'd9);
    if (rec_data.size() == 9) begin
      chk("full_first", 64'(rec_data[0]), 64'h77);
      for (int i = 0; i < 8; i++) chk("full_order", 64'(rec_data[i+1]), 64'(32'h200 + i));
    end

    // Packet lock versus beat interleave
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wen = 3'b011; put(0, 32'h100 + i); put(1, 32'h180 + i);
      last = (i == 3) ? 3'b011 : 3'b000;
      tick();
    end
    wen = '0; last = '0;
    tick();
    tready = 1'b1;
    rec_start();
    repeat (10) tick();
    rec_en = 0;
    chk("lock_count", 64'(rec_tid.size()), 64'd8);
    chk("rr_count", 64'(rec_tid_b.size()), 64'd8);
    if (rec_tid.size() == 8 && rec_tid_b.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("lock_tid", 64'(rec_tid[i]), (i < 4) ? 64'd0 : 64'd1);
        chk("rr_tid", 64'(rec_tid_b[i]), 64'(i % 2));
      end
    end

    // Lock holds while the locked channel is empty
    do_reset();
    tready = 1'b1;
    rec_start();
    wen = 3'b001; put(0, 32'h300); last = 3'b000;
    tick();
    wen = 3'b010; put(1, 32'h400); last = 3'b010;
    tick();
    wen = '0; last = '0;
    tick();
    tick();
    wen = 3'b001; put(0, 32'h301); last = 3'b001;
    tick();
    wen = '0; last = '0;
    repeat (6) tick();
    rec_en = 0;
    chk("wait_count", 64'(rec_data.size()), 64'd3);
    if (rec_data.size() == 3) begin
      chk("wait_b0", {rec_data[0], 32'(rec_tid[0])}, {32'h300, 32'd0});
      chk("wait_b1", {rec_data[1], 32'(rec_tid[1])}, {32'h301, 32'd0});
      chk("wait_b2", {rec_data[2], 32'(rec_tid[2])}, {32'h400, 32'd1});
    end

    // Reset in the middle of a packet
    do_reset();
    tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wen = 3'b001; put(0, 32'h500 + i); last = (i == 3) ? 3'b001 : 3'b000;
      tick();
    end
    wen = '0; last = '0;
    tick();
    tready = 1'b1;
    tick();
    tick();
    chk("mid_pkt_b2", {tvalid, tdata}, {1'b1, 32'h502});
    rst = 1'b1;
    #1;
    chk("rst_async_tvalid", 64'(tvalid), 64'h0);
    chk("rst_async_rdy", 64'(rdy), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_rdy_after", 64'(rdy), 64'h7);
    rec_start();
    repeat (6) tick();
    rec_en = 0;
    chk("rst_no_stale", 64'(rec_data.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_dispatcher.md
MULTI_DISPATCHER -- requirements
Module: multi_dispatcher

Interface
REQ-001 Parameter DATAW, default 512: tdata width in bits, tuser excluded.
REQ-002 Parameter IDW, default 2: axis tid width in bits.
REQ-003 Parameter DESTW, default 4: axis tdest width in bits.
REQ-004 Parameter NUM_CH, default 3: number of input channels, 1..2^IDW.
REQ-005 Parameter FIFO_DEPTH, default 8: entries per channel FIFO, power of two, at least 2.
REQ-006 Parameter DEST_NODES, default {4'd9,4'd1,4'd2}: packed NUM_CH*DESTW vector; channel c destination is DEST_NODES[c*DESTW +: DESTW].
REQ-007 Parameter PACKET_LOCK, default 1: 1 = packet-granular arbitration, 0 = beat-granular arbitration.
REQ-008 Port clk, input, 1: single clock for all logic.
REQ-009 Port rst, input, 1: reset, asynchronous, active-high.
REQ-010 Port data_fifo_wen, input, NUM_CH: per-channel write strobe.
REQ-011 Port data_fifo_wdata, input, NUM_CH*DATAW: channel c data is at [c*DATAW +: DATAW].
REQ-012 Port data_last, input, NUM_CH: per-channel end-of-packet flag, qualified by wen.
REQ-013 Port data_fifo_rdy, output, NUM_CH: per-channel FIFO not full.
REQ-014 Ports axis_tx_tvalid (output, 1), axis_tx_tdata (output, DATAW), axis_tx_tid (output, IDW), axis_tx_tdest (output, DESTW), axis_tx_tlast (output, 1), axis_tx_tready (input, 1): AXI-S transmit toward the NoC.

Function
REQ-015 Each channel SHALL own a FIFO of FIFO_DEPTH entries holding {last, data}; the write occurs when wen[c] and rdy[c] are both high, and wen while rdy is low SHALL be ignored with no state change.
REQ-016 rdy[c] SHALL equal (count[c] < FIFO_DEPTH); a channel that is full SHALL accept a write in the cycle after a pop.
REQ-017 There SHALL be no fall-through: an entry written at edge k becomes eligible for arbitration after edge k, and axis_tx_tvalid rises after edge k+1 at the earliest.
REQ-018 The output stage SHALL be a single register; it loads when (!tvalid || tready), and tdata/tid/tdest/tlast SHALL hold stable while tvalid && !tready.
REQ-019 With tready held high and data pending, throughput SHALL be one beat per cycle with no bubbles, including across channel switches.
REQ-020 Arbitration SHALL be round-robin over non-empty channels, with the search starting at (last_granted+1) mod NUM_CH.
REQ-021 With PACKET_LOCK=1, after a non-last beat is popped from channel c, the grant SHALL stay locked on c until its last beat is popped, and other channels SHALL wait even while c is empty.
REQ-022 With PACKET_LOCK=0, the pointer SHALL advance after every popped beat.
REQ-023 axis_tx_tid SHALL equal the source channel index; axis_tx_tdest SHALL equal that channel's DEST_NODES slice; axis_tx_tlast SHALL equal the stored last flag.
REQ-024 Elaboration SHALL fail if NUM_CH > 2^IDW or FIFO_DEPTH is not a power of two of at least 2.
REQ-025 A simultaneous write and pop on the same channel SHALL leave count unchanged, and pointer wrap-around SHALL be modulo FIFO_DEPTH.

Reset
REQ-026 While rst=1, the block SHALL hold: FIFO pointers and counts 0, rdy all 0, axis_tx_tvalid 0, tlast 0, tdata 0, tid 0, tdest 0, round-robin pointer such that channel 0 wins first, lock cleared.
REQ-027 After rst deasserts, rdy SHALL be all 1 at the first edge.
REQ-028 Reset asserted mid-packet SHALL discard all buffered and in-flight beats immediately and asynchronously.

Verification
REQ-029 Single beat: ch0 writes 0xA5 with last=1, tready=1 -> exactly one beat with tdata=0xA5, tid=0, tdest=2, tlast=1, two edges after the write.
REQ-030 Backpressure: ch1 writes 3 beats with tready=0 -> tvalid=1 with tdata fixed at beat0 until tready=1; beats are then delivered in order with tid=1, tdest=1.
REQ-031 Full: FIFO_DEPTH=8, ch2 writes 9 times with tready=0 -> rdy[2]=0 after the 8th write; the 9th write is dropped; 8 beats are delivered.
REQ-032 Lock: PACKET_LOCK=1, ch0 and ch1 each hold a 4-beat packet -> output is ch0 x4 then ch1 x4 with no interleave; with PACKET_LOCK=0 the output alternates 0,1,0,1...
REQ-033 Reset mid-packet: assert rst after 2 of 4 beats -> tvalid=0 immediately; after release no stale beats appear and rdy is all 1.
